echo_mixer: RTL and testbench

Downstream consumer of the signal-delay stage: mixes each live mic sample with the delayed sample read back from the dual-port delay RAM, scaled by a programmable echo gain, and produces a saturated offset-binary output sample with a valid strobe. It aligns the live sample to the RAM's 1-cycle read latency internally, is fully pipelined at one sample per clock, and flags clipping.

---
 rtl/echo_mixer.sv | 140 ++++++++++++++
 tb/tb_echo_mixer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/echo_mixer.sv
// Echo mixer: live mic plus gain-scaled delayed sample, saturated offset-binary output.
// Define PEAK_HOLD_EN to build the decaying peak meter; otherwise peak is tied to 0.
module echo_mixer #(
    parameter int unsigned D_WIDTH = 8,
    parameter int unsigned G_WIDTH = 4,
    parameter int unsigned DECAY_W = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [D_WIDTH-1:0] mic_signal,
    input  logic [D_WIDTH-1:0] delayed_signal,
    input  logic [G_WIDTH-1:0] gain,
    input  logic               bypass,
    input  logic               clip_clr,
    output logic [D_WIDTH-1:0] mix_out,
    output logic               mix_valid,
    output logic               clip,
    output logic [D_WIDTH-1:0] peak
);
    localparam int unsigned PW = D_WIDTH + G_WIDTH + 2;
    localparam logic [D_WIDTH-1:0] MID = {1'b1, {(D_WIDTH-1){1'b0}}};
    localparam logic signed [PW-1:0] SAT_MAX = PW'((1 << (D_WIDTH-1)) - 1);
    localparam logic signed [PW-1:0] SAT_MIN = PW'(-(1 << (D_WIDTH-1)));

    // Stage 0
    logic [D_WIDTH-1:0] mic_q;
    logic [G_WIDTH-1:0] gain_q;
    logic               byp0_q, v0_q;

    // Stage 1
    logic signed [D_WIDTH:0] m_c, d_c, m_q;
    logic signed [PW-1:0]    d_ext, g_ext, p_c, p_q;
    logic                    byp1_q, v1_q;

    // Stage 2
    logic signed [PW-1:0]      m_ext, s_c;
    logic signed [D_WIDTH-1:0] sat_c;
    logic                      sat_hi, sat_lo;
    logic [D_WIDTH-1:0]        out_c, mix_q;
    logic                      valid_q, clip_q;

    always_comb begin
        m_c   = $signed({1'b0, mic_q}) - $signed({1'b0, MID});
        d_c   = $signed({1'b0, delayed_signal}) - $signed({1'b0, MID});
        d_ext = {{(PW-D_WIDTH-1){d_c[D_WIDTH]}}, d_c};
        g_ext = {{(PW-G_WIDTH){1'b0}}, gain_q};
        p_c   = d_ext * g_ext;
    end

    always_comb begin
        m_ext  = {{(PW-D_WIDTH-1){m_q[D_WIDTH]}}, m_q};
        // Arithmetic shift floors toward -inf, matching the gain scaling definition.
        s_c    = m_ext + (p_q >>> G_WIDTH);
        sat_hi = s_c > SAT_MAX;
        sat_lo = s_c < SAT_MIN;
        if (sat_hi) begin
            sat_c = SAT_MAX[D_WIDTH-1:0];
        end else if (sat_lo) begin
            sat_c = SAT_MIN[D_WIDTH-1:0];
        end else begin
            sat_c = s_c[D_WIDTH-1:0];
        end
        // Bypass restores the captured mic sample by undoing the centring offset.
        out_c = byp1_q ? {~m_q[D_WIDTH-1], m_q[D_WIDTH-2:0]}
                       : {~sat_c[D_WIDTH-1], sat_c[D_WIDTH-2:0]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mic_q   <= '0;
            gain_q  <= '0;
            byp0_q  <= 1'b0;
            v0_q    <= 1'b0;
            m_q     <= '0;
            p_q     <= '0;
            byp1_q  <= 1'b0;
            v1_q    <= 1'b0;
            mix_q   <= MID;
            valid_q <= 1'b0;
            clip_q  <= 1'b0;
        end else begin
            v0_q <= en;
            if (en) begin
                mic_q  <= mic_signal;
                gain_q <= gain;
                byp0_q <= bypass;
            end
            m_q     <= m_c;
            p_q     <= p_c;
            byp1_q  <= byp0_q;
            v1_q    <= v0_q;
            valid_q <= v1_q;
            if (v1_q) begin
                mix_q <= out_c;
            end
            // A new saturation event wins over a simultaneous clear.
            if (v1_q && !byp1_q && (sat_hi || sat_lo)) begin
                clip_q <= 1'b1;
            end else if (clip_clr) begin
                clip_q <= 1'b0;
            end
        end
    end

    assign mix_out   = mix_q;
    assign mix_valid = valid_q;
    assign clip      = clip_q;

`ifdef PEAK_HOLD_EN
    logic [D_WIDTH-1:0] peak_q, mag_c;
    logic [DECAY_W-1:0] dcnt_q;

    // Magnitude from the offset-binary result; MID - 0 yields the full 2^(D_WIDTH-1).
    assign mag_c = out_c[D_WIDTH-1] ? (out_c - MID) : (MID - out_c);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            peak_q <= '0;
            dcnt_q <= '0;
        end else if (v1_q) begin
            if (mag_c >= peak_q) begin
                peak_q <= mag_c;
                dcnt_q <= '0;
            end else begin
                dcnt_q <= dcnt_q + 1'b1;
                // mag < peak here, so peak is nonzero and cannot underflow.
                if (&dcnt_q) begin
                    peak_q <= peak_q - 1'b1;
                end
            end
        end
    end

    assign peak = peak_q;
`else
    assign peak = '0;
`endif

endmodule

// File: tb/tb_echo_mixer.sv
// Directed self-checking bench for echo_mixer (peak checks depend on PEAK_HOLD_EN).
module tb_echo_mixer;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [7:0] mic_signal = '0;
    logic [7:0] delayed_signal = '0;
    logic [3:0] gain = '0;
    logic       bypass = 1'b0;
    logic       clip_clr = 1'b0;
    logic [7:0] mix_out;
    logic       mix_valid;
    logic       clip;
    logic [7:0] peak;

    int checks = 0;
    int errors = 0;

    echo_mixer #(
        .D_WIDTH(8),
        .G_WIDTH(4),
        .DECAY_W(2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .mic_signal    (mic_signal),
        .delayed_signal(delayed_signal),
        .gain          (gain),
        .bypass        (bypass),
        .clip_clr      (clip_clr),
        .mix_out       (mix_out),
        .mix_valid     (mix_valid),
        .clip          (clip),
        .peak          (peak)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated sample; clr2 drives clip_clr during the cycle ending at E2.
    task automatic send(input string tag, input logic [7:0] mic, input logic [7:0] dly,
                        input logic [3:0] g, input logic byp, input logic clr2,
                        input logic [7:0] exp_out);
        en = 1'b1; mic_signal = mic; gain = g; bypass = byp;
        step();
        en = 1'b0; delayed_signal = dly; mic_signal = 8'h55; gain = 4'h0; bypass = 1'b0;
        step();
        check_eq({tag, "_lat"}, {31'd0, mix_valid}, 32'd0);
        clip_clr = clr2;
        step();
        clip_clr = 1'b0;
        check_eq({tag, "_vld"}, {31'd0, mix_valid}, 32'd1);
        check_eq({tag, "_out"}, {24'd0, mix_out}, {24'd0, exp_out});
        step();
        check_eq({tag, "_pulse"}, {31'd0, mix_valid}, 32'd0);
    endtask

    logic [7:0] bmic [4] = '{8'h90, 8'hA0, 8'h70, 8'h60};
    logic [7:0] bdly [4] = '{8'hB0, 8'h40, 8'h80, 8'hFF};
    logic [7:0] bexp [4] = '{8'hA8, 8'h80, 8'h70, 8'h9F};

    initial begin
        // Reset held with en toggling
        for (int i = 0; i < 4; i++) begin
            en = ~en; mic_signal = 8'hF0; delayed_signal = 8'hFF; gain = 4'hF;
            step();
            check_eq("rst_vld", {31'd0, mix_valid}, 32'd0);
        end
        check_eq("rst_out", {24'd0, mix_out}, 32'h80);
        check_eq("rst_clip", {31'd0, clip}, 32'd0);
        check_eq("rst_peak", {24'd0, peak}, 32'd0);
        en = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("rel_vld", {31'd0, mix_valid}, 32'd0);
        end

        send("mix", 8'hA0, 8'hC0, 4'd8, 1'b0, 1'b0, 8'hC0);
        check_eq("mix_clip", {31'd0, clip}, 32'd0);
        send("sat_hi", 8'hF0, 8'hFF, 4'd15, 1'b0, 1'b0, 8'hFF);
        check_eq("sat_hi_clip", {31'd0, clip}, 32'd1);
        send("sat_lo", 8'h00, 8'h00, 4'd15, 1'b0, 1'b0, 8'h00);
        check_eq("sat_lo_clip", {31'd0, clip}, 32'd1);
        send("setclr", 8'hF0, 8'hFF, 4'd15, 1'b0, 1'b1, 8'hFF);
        check_eq("setclr_clip", {31'd0, clip}, 32'd1);
        clip_clr = 1'b1;
        step();
        clip_clr = 1'b0;
        check_eq("clr_clip", {31'd0, clip}, 32'd0);

        send("floor", 8'h80, 8'h7F, 4'd1, 1'b0, 1'b0, 8'h7F);
        send("byp", 8'h37, 8'hFF, 4'd15, 1'b1, 1'b0, 8'h37);
        send("byp_big", 8'hF7, 8'hFF, 4'd15, 1'b1, 1'b0, 8'hF7);
        check_eq("byp_clip", {31'd0, clip}, 32'd0);
        send("g0", 8'h5A, 8'hFF, 4'd0, 1'b0, 1'b0, 8'h5A);
        step();
        check_eq("hold_out", {24'd0, mix_out}, 32'h5A);

        // Back-to-back burst; delayed sample k arrives alongside mic sample k+1
        gain = 4'd8;
        for (int c = 0; c < 8; c++) begin
            en = (c < 4);
            mic_signal = (c < 4) ? bmic[c] : 8'h00;
            delayed_signal = (c >= 1 && c <= 4) ? bdly[c-1] : 8'h00;
            step();
            if (c + 1 >= 3 && c + 1 <= 6) begin
                check_eq($sformatf("burst_vld%0d", c - 2), {31'd0, mix_valid}, 32'd1);
                check_eq($sformatf("burst_out%0d", c - 2), {24'd0, mix_out}, {24'd0, bexp[c-2]});
            end else begin
                check_eq("burst_gap", {31'd0, mix_valid}, 32'd0);
            end
        end

        // Second burst cut by reset one cycle after its 2nd en edge
        en = 1'b1; mic_signal = 8'hFF; gain = 4'd0;
        step();
        delayed_signal = 8'hFF;
        step();
        en = 1'b0;
        rst = 1'b0;
        #1;
        check_eq("midrst_vld", {31'd0, mix_valid}, 32'd0);
        check_eq("midrst_out", {24'd0, mix_out}, 32'h80);
        step();
        step();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("drop_vld", {31'd0, mix_valid}, 32'd0);
        end

        // Peak: one sample of magnitude 100 then silence, continuous stream
        gain = 4'd0;
        for (int c = 0; c < 12; c++) begin
            en = (c < 9);
            mic_signal = (c == 0) ? 8'hE4 : 8'h80;
            step();
`ifdef PEAK_HOLD_EN
            if (c + 1 == 3) check_eq("peak_hit", {24'd0, peak}, 32'd100);
            if (c + 1 == 6) check_eq("peak_hold", {24'd0, peak}, 32'd100);
            if (c + 1 == 7) check_eq("peak_dec1", {24'd0, peak}, 32'd99);
            if (c + 1 == 11) check_eq("peak_dec2", {24'd0, peak}, 32'd98);
`else
            if (c + 1 == 3) check_eq("peak_off", {24'd0, peak}, 32'd0);
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
